psdifir_mc: RTL and testbench
=============================

PSDIFIR_MC -- requirements
Module: psdifir_mc

Interface
REQ-001 Parameters: NCH, default 2, number of audio channels.
REQ-002 Parameters: DW, default 18, sample width, two's complement.
REQ-003 Parameters: CW, default 18, coefficient width, two's complement.
REQ-004 Parameters: NTAPS, default 64, taps per channel, power of 2, minimum 4.
REQ-005 Parameters: OUTSHIFT, default 17, number of fractional bits dropped from the accumulator.
REQ-006 Ports: clock  in  1  master clock, active on the posedge.
REQ-007 Ports: reset  in  1  master reset, asynchronous, active-low.
REQ-008 Ports: datain_ready  in  1  one-cycle strobe; datain holds one new sample per channel.
REQ-009 Ports: datain  in  NCH*DW  channel c is at bits [c*DW +: DW].
REQ-010 Ports: coef_we  in  1  coefficient write enable.
REQ-011 Ports: coef_addr  in  log2(NCH*NTAPS)  address = c*NTAPS + k, where k is the tap index.
REQ-012 Ports: coef_data  in  CW  coefficient h_c[k].
REQ-013 Ports: dataout  out  NCH*DW  filtered samples, packed the same way as datain.
REQ-014 Ports: dataout_ready  out  1  one-cycle pulse; dataout has been updated.
REQ-015 Ports: busy  out  1  computation in progress.
REQ-016 Ports: overrun  out  1  sticky flag; a datain_ready strobe was dropped.

Function
REQ-017 Output: y_c[n] = sum over k=0..NTAPS-1 of h_c[k]*x_c[n-k].
  - The block uses exactly one multiplier, time-multiplexed over channels and taps.
REQ-018 State machine states: IDLE, MAC, FLUSH, DONE.
REQ-019 IDLE:
  - On datain_ready, write all NCH samples into per-channel circular buffers at wptr.
  - Go to MAC.
REQ-020 MAC:
  - One tap per cycle, channel 0 first.
  - Per channel, taps run k=0..NTAPS-1, reading buffer address (wptr-k) mod NTAPS.
  - NCH*NTAPS cycles in total.
  - Go to FLUSH.
REQ-021 FLUSH: drain the pipeline (buffer read, registered product, accumulate) in 3 cycles, then go to DONE.
REQ-022 DONE:
  - Register all channel results into dataout and pulse dataout_ready for 1 cycle.
  - Increment wptr mod NTAPS and return to IDLE.
REQ-023 Latency: dataout_ready asserts exactly NCH*NTAPS+4 posedges after the edge that samples datain_ready.
  - Minimum strobe spacing is therefore NCH*NTAPS+5 cycles.
REQ-024 busy is high from the edge after datain_ready is sampled up to and including the DONE cycle.
REQ-025 Accumulator width is DW+CW+log2(NTAPS) bits, so accumulation cannot overflow.
  - The accumulator is cleared at the start of each channel.
REQ-026 Result = (acc + 2^(OUTSHIFT-1)) >>> OUTSHIFT, i.e. round half up; with OUTSHIFT=0 there is no rounding.
  - The result saturates to [-2^(DW-1), 2^(DW-1)-1].
REQ-027 History fill:
  - A fill counter, saturating at NTAPS, counts accepted samples since reset.
  - Taps with k >= fill contribute 0, so stale RAM contents never reach the output.
REQ-028 datain_ready while busy:
  - The strobe is ignored and the buffer is not written.
  - overrun is set and stays high until reset.
  - The computation in progress is unaffected.
REQ-029 Coefficient writes:
  - Accepted only in IDLE, including the cycle in which datain_ready is sampled.
  - coef_we while busy is ignored.
REQ-030 Coefficient memory contents are undefined until written.
REQ-031 dataout holds its value between dataout_ready pulses.

Reset
REQ-032 While reset=0, and immediately on assertion:
  - state=IDLE, busy=0, dataout_ready=0, dataout=0, overrun=0, wptr=0, fill=0, accumulator=0.
REQ-033 Reset asserted mid-computation aborts it with no dataout_ready pulse.
  - The next accepted sample is computed against an empty history.
REQ-034 Reset does not clear coefficient memory or buffer RAM.
  - The fill counter masks stale buffer RAM, per REQ-027.
REQ-035 Reset deassertion is synchronised internally.
  - The first datain_ready honoured is on the second posedge after release.

Verification
All scenarios use NCH=2, NTAPS=8, DW=CW=18 unless stated otherwise.
REQ-036 Impulse, OUTSHIFT=0:
  - Stimulus: h_0[k]=k+1, h_1[k]=-(k+1); ch0 x=1000, ch1 x=1000 at n=0, then zeros.
  - Required: ch0 outputs 1000, 2000, ..., 8000, then 0; ch1 outputs the negated sequence.
REQ-037 Latency:
  - Stimulus: single strobe at edge T.
  - Required: dataout_ready high only at edge T+20; busy high for edges T+1 through T+20.
REQ-038 Saturation, OUTSHIFT=0, all coefficients 131071:
  - Constant x=131071 gives output 131071 from the first sample.
  - Constant x=-131072 gives output -131072.
REQ-039 Rounding, OUTSHIFT=1, h[0]=1, other coefficients 0:
  - x=3 gives 2; x=-3 gives -1; x=4 gives 2.
REQ-040 Overrun:
  - Stimulus: strobe at T, second strobe at T+6.
  - Required: overrun=1 from T+7; output at T+20 equals the single-sample result; buffer holds one sample.
  - A later coef_we during busy leaves the coefficients unchanged.
REQ-041 Reset mid-computation:
  - Stimulus: reset=0 at T+10.
  - Required: outputs 0 immediately and no pulse.
  - After release, an impulse test reproduces REQ-036 exactly, proving that fill masking works.

Source files
------------

// File: rtl/psdifir_mc.sv
// psdifir_mc: multi-channel FIR filter that shares one multiplier across
// every channel and tap. Each accepted sample set runs one pass of
// NCH*NTAPS multiply-accumulates, drains a three-stage pipeline, and then
// publishes one rounded, saturated result per channel.
module psdifir_mc #(
  parameter int NCH      = 2,
  parameter int DW       = 18,
  parameter int CW       = 18,
  parameter int NTAPS    = 64,
  parameter int OUTSHIFT = 17,
  localparam int AW      = $clog2(NCH * NTAPS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              datain_ready,
  input  logic [NCH*DW-1:0] datain,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [CW-1:0]     coef_data,
  output logic [NCH*DW-1:0] dataout,
  output logic              dataout_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int TW   = $clog2(NTAPS);
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + TW;
  localparam int FW   = TW + 1;

  localparam logic signed [ACCW:0] RND =
    (OUTSHIFT > 0) ? ((ACCW+1)'(1) << ((OUTSHIFT > 0) ? OUTSHIFT - 1 : 0)) : '0;
  localparam logic signed [ACCW:0] SAT_MAX = (ACCW+1)'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [ACCW:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, FLUSH, DONE} state_t;

  state_t state, state_nxt;

  logic            run_en;
  logic            accept;
  logic [TW-1:0]   wptr;
  logic [TW-1:0]   tap, tap_nxt;
  logic [CHW-1:0]  chan, chan_nxt;
  logic [1:0]      flush_cnt, flush_cnt_nxt;
  logic [FW-1:0]   fill;
  logic [TW-1:0]   rd_tap;
  logic [AW-1:0]   buf_rd_addr;
  logic [AW-1:0]   coef_rd_addr;
  logic            tap_live;

  logic signed [DW-1:0] buf_mem  [NCH*NTAPS];
  logic signed [CW-1:0] coef_mem [NCH*NTAPS];

  logic                 s1_valid, s1_first, s1_last;
  logic [CHW-1:0]       s1_chan;
  logic signed [DW-1:0] s1_x;
  logic signed [CW-1:0] s1_h;

  logic                 p_valid, p_first, p_last;
  logic [CHW-1:0]       p_chan;
  logic signed [PW-1:0] prod;

  logic signed [ACCW-1:0] acc, acc_sum;
  logic signed [ACCW:0]   rounded, shifted;
  logic signed [DW-1:0]   sat_val;
  logic signed [DW-1:0]   result [NCH];
  logic [NCH*DW-1:0]      result_flat;

  assign accept       = datain_ready && run_en && (state == IDLE);
  assign rd_tap       = wptr - tap;
  assign buf_rd_addr  = AW'(int'(chan) * NTAPS) + AW'(rd_tap);
  assign coef_rd_addr = AW'(int'(chan) * NTAPS) + AW'(tap);
  assign tap_live     = ({1'b0, tap} < fill);

  // Hold off sample acceptance for one edge after reset is released
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) run_en <= 1'b0;
    else        run_en <= 1'b1;
  end

  // Sample history and coefficient storage; neither is cleared by reset
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int c = 0; c < NCH; c++)
        buf_mem[AW'(c * NTAPS) + AW'(wptr)] <= datain[c*DW +: DW];
    end
    if (coef_we && (state == IDLE))
      coef_mem[coef_addr] <= coef_data;
  end

  // Sequencer registers: state, tap/channel walk and flush counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tap       <= '0;
      chan      <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      tap       <= tap_nxt;
      chan      <= chan_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next-state logic: walk taps of channel 0 first, then drain and publish
  always_comb begin
    state_nxt     = state;
    tap_nxt       = tap;
    chan_nxt      = chan;
    flush_cnt_nxt = flush_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = MAC;
          tap_nxt   = '0;
          chan_nxt  = '0;
        end
      end
      MAC: begin
        tap_nxt = tap + 1'b1;
        if (tap == TW'(NTAPS - 1)) begin
          if (chan == CHW'(NCH - 1)) begin
            state_nxt     = FLUSH;
            chan_nxt      = '0;
            flush_cnt_nxt = '0;
          end else begin
            chan_nxt = chan + 1'b1;
          end
        end
      end
      FLUSH: begin
        flush_cnt_nxt = flush_cnt + 1'b1;
        if (flush_cnt == 2'd2) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pipeline control: tag each fetched tap with its channel and position
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_chan  <= '0;
      p_valid  <= 1'b0;
      p_first  <= 1'b0;
      p_last   <= 1'b0;
      p_chan   <= '0;
    end else begin
      s1_valid <= (state == MAC);
      s1_first <= (tap == '0);
      s1_last  <= (tap == TW'(NTAPS - 1));
      s1_chan  <= chan;
      p_valid  <= s1_valid;
      p_first  <= s1_first;
      p_last   <= s1_last;
      p_chan   <= s1_chan;
    end
  end

  // Pipeline data: fetch operands (masking unfilled history), then multiply
  always_ff @(posedge clock) begin
    s1_x <= tap_live ? buf_mem[buf_rd_addr] : '0;
    s1_h <= coef_mem[coef_rd_addr];
    prod <= s1_x * s1_h;
  end

  // Accumulate, round half up, and clamp to the output range
  always_comb begin
    acc_sum = acc + ACCW'(prod);
    if (p_first) acc_sum = ACCW'(prod);
    rounded = (ACCW+1)'(acc_sum) + RND;
    shifted = rounded >>> OUTSHIFT;
    sat_val = shifted[DW-1:0];
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[DW-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[DW-1:0];
  end

  // Accumulator and per-channel result capture on each channel's last tap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      for (int c = 0; c < NCH; c++) result[c] <= '0;
    end else if (p_valid) begin
      acc <= acc_sum;
      if (p_last) result[p_chan] <= sat_val;
    end
  end

  // Pack channel results in the same layout as datain
  always_comb begin
    result_flat = '0;
    for (int c = 0; c < NCH; c++) result_flat[c*DW +: DW] = result[c];
  end

  // Output registers, write pointer, history fill count and overrun flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dataout       <= '0;
      dataout_ready <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      wptr          <= '0;
      fill          <= '0;
    end else begin
      busy          <= accept || (state != IDLE);
      dataout_ready <= (state == DONE);
      if (state == DONE) begin
        dataout <= result_flat;
        wptr    <= wptr + 1'b1;
      end
      if (accept && (fill != FW'(NTAPS)))
        fill <= fill + 1'b1;
      if (datain_ready && (state != IDLE))
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psdifir_mc.sv
// Testbench for psdifir_mc: two instances (OUTSHIFT 0 and 1) share all
// inputs; results are compared with a tap-sum reference model and with
// hand-computed tables for impulse, saturation, rounding, overrun and
// mid-computation reset scenarios.
module tb_psdifir_mc;

  localparam int NCH   = 2;
  localparam int DW    = 18;
  localparam int CW    = 18;
  localparam int NTAPS = 8;
  localparam int AW    = 4;
  localparam int LAT   = NCH * NTAPS + 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              datain_ready = 1'b0;
  logic [NCH*DW-1:0] datain = '0;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [CW-1:0]     coef_data = '0;

  logic [NCH*DW-1:0] dout0, dout1;
  logic              rdy0, rdy1, busy0, busy1, ovr0, ovr1;

  int nvec = 0;
  int nmis = 0;

  int coefM [NCH][NTAPS];
  int histM [NCH][NTAPS];
  int histLen = 0;

  typedef struct {
    int x0;
    int x1;
    int y0;
    int y1;
  } vec_t;

  vec_t tbl [9];

  psdifir_mc #(.NCH(NCH), .DW(DW), .CW(CW), .NTAPS(NTAPS), .OUTSHIFT(0)) u_dut0 (
    .clock(clock), .reset(reset), .datain_ready(datain_ready), .datain(datain),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .dataout(dout0), .dataout_ready(rdy0), .busy(busy0), .overrun(ovr0));

  psdifir_mc #(.NCH(NCH), .DW(DW), .CW(CW), .NTAPS(NTAPS), .OUTSHIFT(1)) u_dut1 (
    .clock(clock), .reset(reset), .datain_ready(datain_ready), .datain(datain),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .dataout(dout1), .dataout_ready(rdy1), .busy(busy1), .overrun(ovr1));

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int getCh(logic [NCH*DW-1:0] d, int c);
    logic signed [DW-1:0] v;
    v = d[c*DW +: DW];
    return int'(v);
  endfunction

  // Reference: y = sum h[k]*x[n-k] over the filled history, round, clamp
  function automatic int modelOut(int c, int shift);
    longint acc;
    acc = 0;
    for (int k = 0; k < histLen; k++)
      acc += longint'(coefM[c][k]) * longint'(histM[c][k]);
    if (shift > 0) acc = (acc + (longint'(1) << (shift - 1))) >>> shift;
    if (acc > 131071)  acc = 131071;
    if (acc < -131072) acc = -131072;
    return int'(acc);
  endfunction

  function automatic void modelPush(int x0, int x1);
    for (int k = NTAPS - 1; k > 0; k--) begin
      histM[0][k] = histM[0][k-1];
      histM[1][k] = histM[1][k-1];
    end
    histM[0][0] = x0;
    histM[1][0] = x1;
    if (histLen < NTAPS) histLen++;
  endfunction

  function automatic void modelReset();
    histLen = 0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NTAPS; k++) histM[c][k] = 0;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    nvec++;
    if (actual !== expected) begin
      nmis++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic writeCoef(int addr, int val);
    @(negedge clock);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = CW'(val);
    @(posedge clock);
    #1 coef_we = 1'b0;
  endtask

  // mode 0: h0=k+1, h1=-(k+1); 1: all 131071; 2: h[0]=1 only; 3: random small
  task automatic loadCoefs(int mode);
    int v;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < NTAPS; k++) begin
        case (mode)
          0:       v = (c == 0) ? (k + 1) : -(k + 1);
          1:       v = 131071;
          2:       v = (k == 0) ? 1 : 0;
          default: v = int'($urandom_range(0, 15)) - 8;
        endcase
        writeCoef(c * NTAPS + k, v);
        coefM[c][k] = v;
      end
    end
  endtask

  // Strobe one sample set and wait (bounded) for the result pulse
  task automatic applyStimulus(input int x0, input int x1, input bit pokeCoef,
                               output int lat, output bit busyHeld);
    @(negedge clock);
    datain       = {DW'(x1), DW'(x0)};
    datain_ready = 1'b1;
    @(posedge clock);
    #1 datain_ready = 1'b0;
    modelPush(x0, x1);
    lat      = -1;
    busyHeld = 1'b1;
    for (int i = 1; i <= LAT + 10; i++) begin
      @(posedge clock);
      #1;
      if (pokeCoef && i == 3) begin
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = CW'(999);
      end
      if (i == 4) coef_we = 1'b0;
      if (!busy0) busyHeld = 1'b0;
      if (rdy0) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic runSample(int x0, int x1, bit pokeCoef);
    int lat;
    bit held;
    applyStimulus(x0, x1, pokeCoef, lat, held);
    checkOutput("latency", lat, LAT);
    checkOutput("busy held", int'(held), 1);
    checkOutput("dut0 ch0 model", getCh(dout0, 0), modelOut(0, 0));
    checkOutput("dut0 ch1 model", getCh(dout0, 1), modelOut(1, 0));
    checkOutput("dut1 ch0 model", getCh(dout1, 0), modelOut(0, 1));
    checkOutput("dut1 ch1 model", getCh(dout1, 1), modelOut(1, 1));
  endtask

  task automatic runImpulseTable();
    for (int i = 0; i < 9; i++) begin
      runSample(tbl[i].x0, tbl[i].x1, 1'b0);
      checkOutput("impulse ch0", getCh(dout0, 0), tbl[i].y0);
      checkOutput("impulse ch1", getCh(dout0, 1), tbl[i].y1);
    end
  endtask

  initial begin
    int lat;
    int pulses;
    bit held;

    tbl[0] = '{1000, 1000, 1000, -1000};
    for (int i = 1; i < 8; i++) tbl[i] = '{0, 0, 1000 * (i + 1), -1000 * (i + 1)};
    tbl[8] = '{0, 0, 0, 0};
    modelReset();

    $display("[TB] reset state");
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset dataout", int'(dout0), 0);
    checkOutput("reset dataout_ready", int'(rdy0), 0);
    checkOutput("reset busy", int'(busy0), 0);
    checkOutput("reset overrun", int'(ovr0), 0);
    @(negedge clock);
    reset = 1'b1;

    $display("[TB] impulse response");
    loadCoefs(0);
    runImpulseTable();

    $display("[TB] latency and busy window");
    applyStimulus(5, -5, 1'b0, lat, held);
    checkOutput("latency edge", lat, LAT);
    checkOutput("busy through DONE", int'(held), 1);
    @(posedge clock);
    #1;
    checkOutput("busy after DONE", int'(busy0), 0);
    checkOutput("ready single pulse", int'(rdy0), 0);

    $display("[TB] saturation");
    doReset();
    loadCoefs(1);
    runSample(131071, 131071, 1'b0);
    checkOutput("sat pos first", getCh(dout0, 0), 131071);
    runSample(131071, 131071, 1'b0);
    checkOutput("sat pos second", getCh(dout0, 1), 131071);
    doReset();
    runSample(-131072, -131072, 1'b0);
    checkOutput("sat neg first", getCh(dout0, 0), -131072);
    runSample(-131072, -131072, 1'b0);
    checkOutput("sat neg second", getCh(dout0, 1), -131072);

    $display("[TB] rounding");
    doReset();
    loadCoefs(2);
    runSample(3, -3, 1'b0);
    checkOutput("round 3", getCh(dout1, 0), 2);
    checkOutput("round -3", getCh(dout1, 1), -1);
    runSample(4, 4, 1'b0);
    checkOutput("round 4", getCh(dout1, 0), 2);

    $display("[TB] overrun");
    doReset();
    loadCoefs(0);
    @(negedge clock);
    datain       = {DW'(1000), DW'(1000)};
    datain_ready = 1'b1;
    @(posedge clock);
    #1 datain_ready = 1'b0;
    modelPush(1000, 1000);
    repeat (5) @(posedge clock);
    @(negedge clock);
    datain       = {DW'(5555), DW'(5555)};
    datain_ready = 1'b1;
    @(posedge clock);
    #1 datain_ready = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("overrun set", int'(ovr0), 1);
    lat = -1;
    for (int i = 8; i <= LAT + 10; i++) begin
      @(posedge clock);
      #1;
      if (rdy0) begin
        lat = i;
        break;
      end
    end
    checkOutput("overrun latency", lat, LAT);
    checkOutput("overrun ch0", getCh(dout0, 0), 1000);
    checkOutput("overrun ch1", getCh(dout0, 1), -1000);
    runSample(0, 0, 1'b1);
    checkOutput("one sample kept", getCh(dout0, 0), 2000);
    runSample(7, 7, 1'b0);
    checkOutput("coef unchanged", getCh(dout0, 0), 7 + 3000);
    checkOutput("overrun sticky", int'(ovr0), 1);

    $display("[TB] reset mid-computation");
    @(negedge clock);
    datain       = {DW'(777), DW'(777)};
    datain_ready = 1'b1;
    @(posedge clock);
    #1 datain_ready = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checkOutput("abort dataout", int'(dout0), 0);
    checkOutput("abort busy", int'(busy0), 0);
    checkOutput("abort ready", int'(rdy0), 0);
    checkOutput("abort overrun", int'(ovr0), 0);
    modelReset();
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      @(posedge clock);
      #1;
      if (rdy0) pulses++;
    end
    checkOutput("no pulse after abort", pulses, 0);
    runImpulseTable();

    $display("[TB] randomized against model");
    doReset();
    loadCoefs(3);
    for (int n = 0; n < 24; n++) begin
      int x0, x1;
      if ($urandom_range(0, 3) == 0) begin
        x0 = int'($urandom_range(0, 262143)) - 131072;
        x1 = int'($urandom_range(0, 262143)) - 131072;
      end else begin
        x0 = int'($urandom_range(0, 4000)) - 2000;
        x1 = int'($urandom_range(0, 4000)) - 2000;
      end
      runSample(x0, x1, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        int c, k, v;
        c = int'($urandom_range(0, NCH - 1));
        k = int'($urandom_range(0, NTAPS - 1));
        v = int'($urandom_range(0, 15)) - 8;
        writeCoef(c * NTAPS + k, v);
        coefM[c][k] = v;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
